control_pipeline: RTL

CONTROL_PIPELINE -- requirements
Module: control_pipeline

---
 rtl/ctrl_pkg.sv | 105 ++++++++++
 rtl/control_decode.sv | 113 +++++++++++
 rtl/control_pipeline.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings and control-bundle types for the RV32 decode/pipeline control path.
// The D-stage bundle narrows as it moves down the pipe; each stage keeps only what it drives.
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  // M codes sit at 5'b10_xxx so funct3 maps straight into the low bits
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [1:0] ALU_MEXT_HI = 2'b10;

  localparam logic [2:0] RES_ALU   = 3'd0;
  localparam logic [2:0] RES_MEM   = 3'd1;
  localparam logic [2:0] RES_PC4   = 3'd2;
  localparam logic [2:0] RES_IMM   = 3'd3;
  localparam logic [2:0] RES_PCIMM = 3'd4;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_TARGET = 2'b01;
  localparam logic [1:0] PC_JALR   = 2'b10;

  typedef struct packed {
    logic       regwrite;
    logic [2:0] immsrc;
    logic       alusrc;
    logic       memwrite;
    logic [2:0] resultsrc;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [4:0] alucontrol;
    logic [2:0] funct3;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    logic       regwrite;
    logic       alusrc;
    logic       memwrite;
    logic [2:0] resultsrc;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [4:0] alucontrol;
    logic [2:0] funct3;
    logic       illegal;
  } ex_ctrl_t;

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic [2:0] resultsrc;
    logic [2:0] funct3;
    logic       illegal;
  } mem_ctrl_t;

  typedef struct packed {
    logic       regwrite;
    logic [2:0] resultsrc;
  } wb_ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [4:0] r;
    case (f3)
      3'b000:  r = alt ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational RV32I(+M) decoder: instruction word to D-stage control bundle.
// Anything illegal has all side-effecting controls stripped so it can only raise the flag.
module control_decode
  import ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  ctrl_t      c;
  logic       unused_fields;

  assign op = instr_i[6:0];
  assign f3 = instr_i[14:12];
  assign f7 = instr_i[31:25];
  assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

  always_comb begin
    c            = CTRL_BUBBLE;
    c.funct3     = f3;
    c.alucontrol = ALU_ADD;
    case (op)
      OP_OP: begin
        c.regwrite = 1'b1;
        if (f7 == F7_MEXT) begin
          if (ENABLE_M) c.alucontrol = {ALU_MEXT_HI, f3};
          else          c.illegal    = 1'b1;
        end else if (f7 == F7_BASE) begin
          c.alucontrol = alu_from_f3(f3, 1'b0);
        end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
          c.alucontrol = alu_from_f3(f3, 1'b1);
        end else begin
          c.illegal = 1'b1;
        end
      end
      OP_OPIMM: begin
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.immsrc   = IMM_I;
        // only the shifts carry a funct7 that must be checked
        if (f3 == 3'b001) begin
          if (f7 == F7_BASE) c.alucontrol = ALU_SLL;
          else               c.illegal    = 1'b1;
        end else if (f3 == 3'b101) begin
          if (f7 == F7_BASE)     c.alucontrol = ALU_SRL;
          else if (f7 == F7_ALT) c.alucontrol = ALU_SRA;
          else                   c.illegal    = 1'b1;
        end else begin
          c.alucontrol = alu_from_f3(f3, 1'b0);
        end
      end
      OP_LOAD: begin
        c.regwrite  = 1'b1;
        c.alusrc    = 1'b1;
        c.immsrc    = IMM_I;
        c.resultsrc = RES_MEM;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) c.illegal = 1'b1;
      end
      OP_STORE: begin
        c.memwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.immsrc   = IMM_S;
        if (f3[2] || f3 == 3'b011) c.illegal = 1'b1;
      end
      OP_BRANCH: begin
        c.branch     = 1'b1;
        c.immsrc     = IMM_B;
        c.alucontrol = ALU_SUB;
        if (f3 == 3'b010 || f3 == 3'b011) c.illegal = 1'b1;
      end
      OP_JAL: begin
        c.jump      = 1'b1;
        c.regwrite  = 1'b1;
        c.immsrc    = IMM_J;
        c.resultsrc = RES_PC4;
      end
      OP_JALR: begin
        c.jalr      = 1'b1;
        c.regwrite  = 1'b1;
        c.alusrc    = 1'b1;
        c.immsrc    = IMM_I;
        c.resultsrc = RES_PC4;
        if (f3 != 3'b000) c.illegal = 1'b1;
      end
      OP_LUI: begin
        c.regwrite  = 1'b1;
        c.immsrc    = IMM_U;
        c.resultsrc = RES_IMM;
      end
      OP_AUIPC: begin
        c.regwrite  = 1'b1;
        c.immsrc    = IMM_U;
        c.resultsrc = RES_PCIMM;
      end
      default: c.illegal = 1'b1;
    endcase
    if (c.illegal) begin
      c.regwrite = 1'b0;
      c.memwrite = 1'b0;
      c.branch   = 1'b0;
      c.jump     = 1'b0;
      c.jalr     = 1'b0;
    end
  end

  assign ctrl_o = c;

endmodule

// File: rtl/control_pipeline.sv
// Control path of a 5-stage RV32 pipeline: D-stage decode, D->E->M->W control registers,
// E-stage branch resolution and redirect/flush, sticky illegal-instruction flag at W.
module control_pipeline
  import ctrl_pkg::*;
#(
  parameter int ENABLE_M  = 0,
  parameter int ALUCTRL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr_d,
  input  logic                 stall_d,
  input  logic                 zero_e,
  input  logic                 lt_e,
  input  logic                 ltu_e,
  output logic [2:0]           immsrc_d,
  output logic                 alusrc_e,
  output logic [ALUCTRL_W-1:0] alucontrol_e,
  output logic [2:0]           resultsrc_e,
  output logic                 regwrite_e,
  output logic [1:0]           pcsrc_e,
  output logic                 flush_fd,
  output logic                 memwrite_m,
  output logic                 regwrite_m,
  output logic [2:0]           resultsrc_m,
  output logic [2:0]           funct3_m,
  output logic                 regwrite_w,
  output logic [2:0]           resultsrc_w,
  output logic                 illegal_w
);

  if (ALUCTRL_W < 4 || ALUCTRL_W > 5 || (ENABLE_M != 0 && ALUCTRL_W != 5)) begin : g_bad_alu_w
    $error("control_pipeline: ALUCTRL_W must be 5 with ENABLE_M=1, 4 or 5 otherwise");
  end

  ctrl_t     dec_d;
  ex_ctrl_t  ex_d, ex_q;
  mem_ctrl_t mem_d, mem_q;
  wb_ctrl_t  wb_d, wb_q;
  logic      illegal_d, illegal_q;
  logic      take_e;
  logic      unused_alu_msb;

  control_decode #(.ENABLE_M(ENABLE_M != 0)) u_decode (
    .instr_i (instr_d),
    .ctrl_o  (dec_d)
  );

  always_comb begin
    case (ex_q.funct3)
      3'b000:  take_e = zero_e;
      3'b001:  take_e = !zero_e;
      3'b100:  take_e = lt_e;
      3'b101:  take_e = !lt_e;
      3'b110:  take_e = ltu_e;
      3'b111:  take_e = !ltu_e;
      default: take_e = 1'b0;
    endcase
  end

  always_comb begin
    pcsrc_e = PC_PLUS4;
    if (ex_q.jalr)                                pcsrc_e = PC_JALR;
    else if (ex_q.jump || (ex_q.branch && take_e)) pcsrc_e = PC_TARGET;
  end

  assign flush_fd = (pcsrc_e != PC_PLUS4);

  // flush and stall both inject a bubble; flush is listed first as it is the stronger cause
  always_comb begin
    ex_d = '0;
    if (!flush_fd && !stall_d) begin
      ex_d.regwrite   = dec_d.regwrite;
      ex_d.alusrc     = dec_d.alusrc;
      ex_d.memwrite   = dec_d.memwrite;
      ex_d.resultsrc  = dec_d.resultsrc;
      ex_d.branch     = dec_d.branch;
      ex_d.jump       = dec_d.jump;
      ex_d.jalr       = dec_d.jalr;
      ex_d.alucontrol = dec_d.alucontrol;
      ex_d.funct3     = dec_d.funct3;
      ex_d.illegal    = dec_d.illegal;
    end
  end

  always_comb begin
    mem_d.regwrite  = ex_q.regwrite;
    mem_d.memwrite  = ex_q.memwrite;
    mem_d.resultsrc = ex_q.resultsrc;
    mem_d.funct3    = ex_q.funct3;
    mem_d.illegal   = ex_q.illegal;
    wb_d.regwrite   = mem_q.regwrite;
    wb_d.resultsrc  = mem_q.resultsrc;
    illegal_d       = illegal_q | mem_q.illegal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      illegal_q <= illegal_d;
    end
  end

  assign immsrc_d       = dec_d.immsrc;
  assign alusrc_e       = ex_q.alusrc;
  assign alucontrol_e   = ex_q.alucontrol[ALUCTRL_W-1:0];
  assign unused_alu_msb = ex_q.alucontrol[4];
  assign resultsrc_e    = ex_q.resultsrc;
  assign regwrite_e     = ex_q.regwrite;
  assign memwrite_m     = mem_q.memwrite;
  assign regwrite_m     = mem_q.regwrite;
  assign resultsrc_m    = mem_q.resultsrc;
  assign funct3_m       = mem_q.funct3;
  assign regwrite_w     = wb_q.regwrite;
  assign resultsrc_w    = wb_q.resultsrc;
  assign illegal_w      = illegal_q;

endmodule
